// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - round-robin shared-memory arbiter with one-cycle read return
// Optional loader write port enabled by MEM_ARB_OOB_EN.
module mem_arb #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_valid,
    input  logic [NUM_PORTS-1:0]             req_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]             req_ready,
    output logic [NUM_PORTS-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_data,
`ifdef MEM_ARB_OOB_EN
    input  logic [ADDR_WIDTH-1:0]            oob_write_addr,
    input  logic [DATA_WIDTH-1:0]            oob_write_data,
    input  logic                             oob_wen,
`endif
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic [DATA_WIDTH-1:0]            mem_rdata
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [PW-1:0] last_grant_q, last_grant_d;
    logic [PW-1:0] rd_port_q, rd_port_d;
    logic          rd_pending_q, rd_pending_d;
    logic [PW-1:0] winner, cand;
    logic          found;

    // Search begins just past the previous winner so every requester gets a turn.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = PW'((int'(last_grant_q) + i) % NUM_PORTS);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        req_ready    = '0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        last_grant_d = last_grant_q;
        rd_pending_d = 1'b0;
        rd_port_d    = rd_port_q;
        if (rst) begin
`ifdef MEM_ARB_OOB_EN
            if (oob_wen) begin
                mem_we    = 1'b1;
                mem_addr  = oob_write_addr;
                mem_wdata = oob_write_data;
            end else
`endif
            if (found) begin
                req_ready[winner] = 1'b1;
                mem_we            = req_we[winner];
                mem_addr          = req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wdata         = req_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
                last_grant_d      = winner;
                if (!req_we[winner]) begin
                    rd_pending_d = 1'b1;
                    rd_port_d    = winner;
                end
            end
        end
    end

    always_comb begin
        rsp_valid            = '0;
        rsp_valid[rd_port_q] = rd_pending_q;
    end

    assign rsp_data = mem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= PW'(NUM_PORTS - 1);
            rd_pending_q <= 1'b0;
            rd_port_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_pending_q <= rd_pending_d;
            rd_port_q    <= rd_port_d;
        end
    end

endmodule

// File: doc/mem_arb.md
# mem_arb

Parametrised shared-memory arbiter for multi-core builds. It sits between NUM_PORTS processor memory ports and the single `mem` instance inside a multi-core computer top. Arbitration is round-robin, one access per cycle, with fixed single-cycle read latency back to the winning port. The out-of-band loader write port has absolute priority over all processor ports.

## Interface
Parameters:
- NUM_PORTS, 2, number of requester ports (≥1)
- ADDR_WIDTH, 16, memory address width
- DATA_WIDTH, 16, memory data width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_PORTS  per-port request valid
- req_we  in  NUM_PORTS  per-port write (1) / read (0)
- req_addr  in  NUM_PORTS*ADDR_WIDTH  per-port address, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data, same packing
- req_ready  out  NUM_PORTS  grant; a request is accepted when valid & ready
- rsp_valid  out  NUM_PORTS  read data valid for port i
- rsp_data  out  DATA_WIDTH  read data, shared by all ports
- oob_write_addr  in  ADDR_WIDTH  loader address (MEM_ARB_OOB_EN only)
- oob_write_data  in  DATA_WIDTH  loader data (MEM_ARB_OOB_EN only)
- oob_wen  in  1  loader write enable (MEM_ARB_OOB_EN only)
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address, used for both read and write
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after address

## Operation
- State: `last_grant` (pointer, clog2(NUM_PORTS) bits, minimum 1), `rd_pending` (1 bit), `rd_port` (pointer).
- Each cycle, search starts at `last_grant`+1 mod NUM_PORTS and ascends with wrap. The first port with req_valid high wins, and only that port gets req_ready=1. req_ready is combinational from req_valid.
- The winner drives mem_addr and mem_wdata. mem_we = req_we of the winner.
- On the clock edge after a grant: `last_grant` ← winner. If the winner was a read: rd_pending ← 1 and rd_port ← winner. Otherwise rd_pending ← 0.
- rsp_valid[rd_port] = rd_pending; all other rsp_valid bits are 0. rsp_data = mem_rdata, passed through.
- No grant in a cycle: mem_we=0, mem_addr/mem_wdata=0, rd_pending ← 0, `last_grant` unchanged.
- Writes produce no response. Requesters must hold valid/we/addr/wdata stable until accepted.
- OOB write (oob_wen=1):
  - all req_ready=0
  - mem_we=1, with mem_addr/mem_wdata taken from oob
  - `last_grant` unchanged; rd_pending ← 0
  - a read granted the previous cycle still returns its rsp_valid this cycle
- NUM_PORTS=1: port 0 is always the winner when valid.

## Timing
- Grant: same cycle as req_valid, unless OOB is active or a higher-priority port wins.
- Read latency: rsp_valid is high exactly one cycle after acceptance, for one cycle.
- Throughput: one access per cycle. Back-to-back reads from different ports each return on consecutive cycles.
- Reset (rst low, asynchronous):
  - `last_grant` ← NUM_PORTS-1, so port 0 wins first after reset
  - rd_pending ← 0; rsp_valid all 0
  - while rst is low: req_ready all 0 and mem_we=0, including during OOB
- Reset mid-read: the in-flight response is dropped; no rsp_valid after release.
- Released ports: a port that drops req_valid without being granted is legal. It is simply skipped.

## Configuration
- MEM_ARB_OOB_EN defined: the oob_* ports exist, with priority as above.
- MEM_ARB_OOB_EN undefined: the oob_* ports are absent and arbitration runs every cycle. The computer top loads memory through another path.

## Test plan
- Reset release, NUM_PORTS=2, port 0 and port 1 both read (addr 0x10 / 0x20) held continuously:
  - grants alternate 0,1,0,1
  - rsp_valid[0] follows one cycle after each port-0 grant, with rsp_data = mem[0x10]
- Port 1 alone writes 0x0005←0xBEEF, then reads 0x0005:
  - write accepted on cycle 0 with mem_we=1
  - read accepted on cycle 1
  - rsp_valid[1]=1 and rsp_data=0xBEEF on cycle 2
- NUM_PORTS=4, ports 1 and 3 requesting, last_grant=3: port 1 granted, then port 3, then port 1.
- OOB: oob_wen=1 (0x0100←0x1234) while port 0 reads:
  - req_ready=0 and mem_we=1 that cycle
  - port 0 granted the next cycle; a read of 0x0100 returns 0x1234
- Read granted, rst pulled low before the next edge, then released: no rsp_valid is ever asserted; port 0 wins first afterwards.
- MEM_ARB_OOB_EN undefined: same as the first scenario with no oob ports; compiles and passes.
